// File: rtl/bird_collision_detect.sv
// ============================================================================
// Module   : bird_collision_detect
// Brief    : Per-frame bird overlap detector with post-hit grace period.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bird_collision_detect #(
    parameter int unsigned GRACE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       draw_bird,
    input  logic       draw_pipe,
    input  logic       draw_border,
    input  logic       game_over,
    output logic       collision,
    output logic       grace,
    output logic [7:0] hit_count
);

    localparam logic [7:0] c_grace_load = 8'(GRACE_FRAMES);
    localparam bit         c_grace_en   = (GRACE_FRAMES != 0);

    typedef enum logic [0:0] {
        ST_ARMED = 1'b0,
        ST_GRACE = 1'b1
    } state_t;

    state_t     state_q,     state_d;
    logic [7:0] grace_cnt_q, grace_cnt_d;
    logic       frame_hit_q, frame_hit_d;
    logic       collision_q, collision_d;
    logic       grace_q,     grace_d;
    logic [7:0] hit_count_q, hit_count_d;

    logic       w_overlap;

    assign w_overlap = draw_bird & (draw_pipe | draw_border);

    always_comb begin
        state_d     = state_q;
        grace_cnt_d = grace_cnt_q;
        hit_count_d = hit_count_q;
        collision_d = 1'b0;
        // An overlap on the frame's first pixel belongs to the new frame.
        frame_hit_d = w_overlap | (frame_hit_q & ~startOfFrame);

        if (game_over) begin
            frame_hit_d = 1'b0;
            state_d     = ST_ARMED;
            grace_cnt_d = 8'd0;
        end else if (startOfFrame) begin
            case (state_q)
                ST_ARMED: begin
                    if (frame_hit_q) begin
                        collision_d = 1'b1;
                        if (hit_count_q != 8'hFF) begin
                            hit_count_d = hit_count_q + 8'd1;
                        end
                        if (c_grace_en) begin
                            state_d     = ST_GRACE;
                            grace_cnt_d = c_grace_load;
                        end
                    end
                end
                ST_GRACE: begin
                    // Exiting discards the hit latched in the last grace frame.
                    if (grace_cnt_q <= 8'd1) begin
                        state_d     = ST_ARMED;
                        grace_cnt_d = 8'd0;
                    end else begin
                        grace_cnt_d = grace_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d     = ST_ARMED;
                    grace_cnt_d = 8'd0;
                end
            endcase
        end

        grace_d = (state_d == ST_GRACE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_ARMED;
            grace_cnt_q <= 8'd0;
            frame_hit_q <= 1'b0;
            collision_q <= 1'b0;
            grace_q     <= 1'b0;
            hit_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            grace_cnt_q <= grace_cnt_d;
            frame_hit_q <= frame_hit_d;
            collision_q <= collision_d;
            grace_q     <= grace_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign collision = collision_q;
    assign grace     = grace_q;
    assign hit_count = hit_count_q;

endmodule

`default_nettype wire

// File: tb/tb_bird_collision_detect.sv
// ============================================================================
// Module   : tb_bird_collision_detect
// Brief    : Directed self-checking bench; DUTs with 3 and 0 grace frames.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bird_collision_detect;

    localparam int c_frame_len = 64;

    logic       clk = 1'b0;
    logic       resetN;
    logic       sof, bird, pipe, border, go;
    logic       col_a, grace_a, col_z, grace_z;
    logic [7:0] hc_a, hc_z;

    int   n_checks = 0;
    int   n_errors = 0;
    int   pulses_a, pulses_z;
    logic first_a, first_z, grace_a_s, grace_z_s;

    int exp_p[9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int exp_g[9] = '{1, 1, 1, 0, 1, 1, 1, 0, 1};

    always #5 clk = ~clk;

    bird_collision_detect #(.GRACE_FRAMES(3)) dut_a (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .draw_bird(bird), .draw_pipe(pipe), .draw_border(border),
        .game_over(go), .collision(col_a), .grace(grace_a), .hit_count(hc_a)
    );

    bird_collision_detect #(.GRACE_FRAMES(0)) dut_z (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .draw_bird(bird), .draw_pipe(pipe), .draw_border(border),
        .game_over(go), .collision(col_z), .grace(grace_z), .hit_count(hc_z)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One frame: SOF cycle, then body pixels 1..n_ovl overlapping.
    task automatic run_frame(input logic b, input logic p, input logic bd,
                             input int n_ovl, input logic at_sof);
        sof    = 1'b1;
        bird   = at_sof & b;
        pipe   = at_sof & p;
        border = at_sof & bd;
        @(posedge clk); #1;
        first_a   = col_a;
        first_z   = col_z;
        grace_a_s = grace_a;
        grace_z_s = grace_z;
        pulses_a  = int'(col_a);
        pulses_z  = int'(col_z);
        sof = 1'b0;
        for (int i = 1; i < c_frame_len; i++) begin
            bird   = (i <= n_ovl) & b;
            pipe   = (i <= n_ovl) & p;
            border = (i <= n_ovl) & bd;
            @(posedge clk); #1;
            pulses_a += int'(col_a);
            pulses_z += int'(col_z);
        end
        bird = 1'b0; pipe = 1'b0; border = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetN = 1'b0;
        sof = 1'b0; bird = 1'b0; pipe = 1'b0; border = 1'b0; go = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_col", int'(col_a), 0);
        chk("rst_grace", int'(grace_a), 0);
        chk("rst_hc", int'(hc_a), 0);
        chk("rst_hc_z", int'(hc_z), 0);
        @(negedge clk) resetN = 1'b1;
        @(posedge clk); #1;

        // Frame 1 overlap, then overlap in frames 2..10
        run_frame(1, 1, 0, 50, 0);
        chk("f1_no_pulse", pulses_a, 0);
        for (int f = 2; f <= 10; f++) begin
            run_frame(1, 1, 0, 50, 0);
            chk($sformatf("g3_pulses_f%0d", f), pulses_a, exp_p[f-2]);
            chk($sformatf("g3_first_f%0d", f), int'(first_a), exp_p[f-2]);
            chk($sformatf("g3_grace_f%0d", f), int'(grace_a_s), exp_g[f-2]);
            chk($sformatf("g0_pulses_f%0d", f), pulses_z, 1);
            chk($sformatf("g0_first_f%0d", f), int'(first_z), 1);
            chk($sformatf("g0_grace_f%0d", f), int'(grace_z_s), 0);
        end
        chk("g3_hc_f10", int'(hc_a), 3);
        chk("g0_hc_f10", int'(hc_z), 9);

        // Border hit (1 pixel) then pipe+border without bird
        run_frame(0, 0, 0, 0, 0);
        run_frame(0, 0, 0, 0, 0);
        run_frame(1, 0, 1, 1, 0);
        chk("border_armed", int'(grace_a_s), 0);
        run_frame(0, 0, 0, 0, 0);
        chk("border_pulse", pulses_a, 1);
        chk("border_first", int'(first_a), 1);
        chk("border_hc", int'(hc_a), 4);
        chk("border_pulse_z", pulses_z, 1);
        run_frame(0, 0, 0, 0, 0);
        run_frame(0, 0, 0, 0, 0);
        run_frame(0, 1, 1, 20, 0);
        run_frame(0, 0, 0, 0, 0);
        chk("nobird_pulse", pulses_a, 0);
        chk("nobird_pulse_z", pulses_z, 0);
        chk("nobird_hc", int'(hc_a), 4);

        // game_over freeze after overlap during grace
        run_frame(1, 1, 0, 10, 0);
        run_frame(1, 1, 0, 10, 0);
        chk("go_pre_pulse", pulses_a, 1);
        chk("go_pre_grace", int'(grace_a_s), 1);
        chk("go_pre_hc", int'(hc_a), 5);
        go = 1'b1;
        for (int f = 0; f < 5; f++) begin
            run_frame(1, 1, 0, 30, 0);
            chk($sformatf("go_pulse_%0d", f), pulses_a, 0);
            chk($sformatf("go_grace_%0d", f), int'(grace_a_s), 0);
            chk($sformatf("go_pulse_z_%0d", f), pulses_z, 0);
        end
        chk("go_hc_frozen", int'(hc_a), 5);
        go = 1'b0;
        run_frame(1, 1, 0, 30, 0);
        chk("go_rel_empty", pulses_a, 0);
        chk("go_rel_empty_z", pulses_z, 0);
        run_frame(0, 0, 0, 0, 0);
        chk("go_rel_pulse", pulses_a, 1);
        chk("go_rel_first", int'(first_a), 1);
        chk("go_rel_hc", int'(hc_a), 6);
        chk("go_rel_pulse_z", pulses_z, 1);

        // Overlap only on the SOF pixel belongs to the new frame
        run_frame(0, 0, 0, 0, 0);
        run_frame(0, 0, 0, 0, 0);
        run_frame(0, 0, 0, 0, 0);
        chk("sof_armed", int'(grace_a_s), 0);
        run_frame(1, 1, 0, 0, 1);
        chk("sof_same_frame", pulses_a, 0);
        chk("sof_same_frame_z", pulses_z, 0);
        run_frame(0, 0, 0, 0, 0);
        chk("sof_next_frame", pulses_a, 1);
        chk("sof_next_frame_z", pulses_z, 1);
        chk("sof_hc", int'(hc_a), 7);

        // Asynchronous reset mid-grace, with a hit pending
        bird = 1'b1; pipe = 1'b1;
        @(posedge clk); #2;
        resetN = 1'b0;
        #1;
        chk("arst_col", int'(col_a), 0);
        chk("arst_grace", int'(grace_a), 0);
        chk("arst_hc", int'(hc_a), 0);
        chk("arst_hc_z", int'(hc_z), 0);
        bird = 1'b0; pipe = 1'b0;
        @(negedge clk) resetN = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 0, 0, 0, 0);
        chk("arst_lost_hit", pulses_a, 0);
        run_frame(1, 1, 0, 5, 0);
        run_frame(0, 0, 0, 0, 0);
        chk("arst_pulse", pulses_a, 1);
        chk("arst_first", int'(first_a), 1);
        chk("arst_grace_hi", int'(grace_a_s), 1);
        chk("arst_hc_1", int'(hc_a), 1);

        // Saturation: 300 hits on the zero-grace instance
        for (int f = 0; f < 300; f++) begin
            run_frame(1, 0, 1, 2, 0);
        end
        chk("sat_hc", int'(hc_z), 255);
        chk("sat_pulse", pulses_z, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
